// File: rtl/snn_output_tally_if.sv
// Spike-result stream from the neuron stage into the output tally:
// one evaluated neuron per cycle plus an end-of-timestep strobe.
interface snn_output_tally_if #(
    parameter int unsigned ID_W = 10
);
    logic            spike_valid_i;
    logic            spike_i;
    logic [ID_W-1:0] neuron_id_i;
    logic            step_done_i;

    modport master (
        output spike_valid_i,
        output spike_i,
        output neuron_id_i,
        output step_done_i
    );

    modport slave (
        input spike_valid_i,
        input spike_i,
        input neuron_id_i,
        input step_done_i
    );
endinterface

// File: rtl/snn_output_tally.sv
// Output-layer spike tally: counts spikes per output neuron over a programmed
// number of timesteps, then runs a sequential argmax to pick the class.
module snn_output_tally #(
    parameter int unsigned NUM_OUT = 10,
    parameter int unsigned ID_W    = 10,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned IDX_W   = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [7:0]        num_steps_i,
    snn_output_tally_if.slave spk,
    output logic              busy_o,
    output logic              done_o,
    output logic [IDX_W-1:0]  class_o,
    output logic [CNT_W-1:0]  class_count_o,
    output logic              tie_o,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [CNT_W-1:0]  rd_count_o
);

    // Scan index is one bit wider so it can reach NUM_OUT even when NUM_OUT == 2^IDX_W.
    localparam int unsigned SCAN_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count [NUM_OUT];
    logic [7:0]          step_cnt;
    logic [7:0]          num_steps;
    logic [SCAN_W-1:0]   idx;
    logic [IDX_W-1:0]    best;
    logic [CNT_W-1:0]    best_cnt;
    logic                tie;
    logic [CNT_W-1:0]    scan_cnt;
    logic                hit;

    assign hit = spk.spike_valid_i & spk.spike_i;

    // Counter under inspection by the argmax scan.
    always_comb begin
        scan_cnt = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (idx == SCAN_W'(i)) scan_cnt = count[i];
        end
    end

    // Readback mux; out-of-range indices read as zero.
    always_comb begin
        rd_count_o = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_count_o = count[i];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            step_cnt      <= '0;
            num_steps     <= '0;
            idx           <= '0;
            best          <= '0;
            best_cnt      <= '0;
            tie           <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            class_o       <= '0;
            class_count_o <= '0;
            tie_o         <= 1'b0;
            for (int unsigned i = 0; i < NUM_OUT; i++) count[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        for (int unsigned i = 0; i < NUM_OUT; i++) count[i] <= '0;
                        step_cnt      <= '0;
                        num_steps     <= num_steps_i;
                        idx           <= '0;
                        best          <= '0;
                        best_cnt      <= '0;
                        tie           <= 1'b0;
                        class_o       <= '0;
                        class_count_o <= '0;
                        tie_o         <= 1'b0;
                        busy_o        <= 1'b1;
                        done_o        <= 1'b0;
                        state         <= (num_steps_i == 8'd0) ? ARGMAX : ACCUM;
                    end
                end

                ACCUM: begin
                    // Ids outside the output layer never match and are dropped.
                    for (int unsigned i = 0; i < NUM_OUT; i++) begin
                        if (hit && spk.neuron_id_i == ID_W'(i) && count[i] != '1)
                            count[i] <= count[i] + CNT_W'(1);
                    end
                    if (spk.step_done_i) begin
                        step_cnt <= step_cnt + 8'd1;
                        if (8'(step_cnt + 8'd1) == num_steps) begin
                            idx      <= '0;
                            best     <= '0;
                            best_cnt <= '0;
                            tie      <= 1'b0;
                            state    <= ARGMAX;
                        end
                    end
                end

                ARGMAX: begin
                    if (idx == SCAN_W'(NUM_OUT)) begin
                        class_o       <= best;
                        class_count_o <= best_cnt;
                        tie_o         <= tie;
                        busy_o        <= 1'b0;
                        done_o        <= 1'b1;
                        state         <= DONE;
                    end else begin
                        // Strict '>' keeps the lowest index on equal counts.
                        if (scan_cnt > best_cnt) begin
                            best     <= idx[IDX_W-1:0];
                            best_cnt <= scan_cnt;
                            tie      <= 1'b0;
                        end else if (scan_cnt == best_cnt && idx != '0) begin
                            tie <= 1'b1;
                        end
                        idx <= idx + SCAN_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_output_tally.sv
// Randomized bench for snn_output_tally against a count/argmax reference model.
module tb_snn_output_tally;

    localparam int NUM_OUT = 10;
    localparam int ID_W    = 10;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       num_steps;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] class_idx;
    logic [CNT_W-1:0] class_count;
    logic             tie;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_count;

    snn_output_tally_if #(.ID_W(ID_W)) spk_if ();

    snn_output_tally #(
        .NUM_OUT(NUM_OUT), .ID_W(ID_W), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start_i       (start),
        .num_steps_i   (num_steps),
        .spk           (spk_if),
        .busy_o        (busy),
        .done_o        (done),
        .class_o       (class_idx),
        .class_count_o (class_count),
        .tie_o         (tie),
        .rd_idx_i      (rd_idx),
        .rd_count_o    (rd_count)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int model_cnt [NUM_OUT];
    int model_n;
    int model_steps;
    bit model_accum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_OUT; i++) model_cnt[i] = 0;
    endtask

    // One cycle of stimulus; the model only reacts while the design is accumulating.
    task automatic cyc(input bit v, input bit s, input int id, input bit stp, input bit st);
        spk_if.spike_valid_i = v;
        spk_if.spike_i       = s;
        spk_if.neuron_id_i   = ID_W'(id);
        spk_if.step_done_i   = stp;
        start                = st;
        tick();
        spk_if.spike_valid_i = 1'b0;
        spk_if.spike_i       = 1'b0;
        spk_if.neuron_id_i   = '0;
        spk_if.step_done_i   = 1'b0;
        start                = 1'b0;
        if (model_accum) begin
            if (v && s && id < NUM_OUT && model_cnt[id] < CNT_MAX) model_cnt[id]++;
            if (stp) begin
                model_steps++;
                if (model_steps == model_n) model_accum = 0;
            end
        end
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_steps = 8'(n);
        tick();
        start     = 1'b0;
        model_clear();
        model_n     = n;
        model_steps = 0;
        model_accum = (n != 0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_class", 32'(class_idx), 32'd0);
        check("start_ccount", 32'(class_count), 32'd0);
        check("start_tie", 32'(tie), 32'd0);
    endtask

    task automatic wait_done(input int exp_lat);
        int k = 0;
        while (!done && k < 64) begin
            tick();
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        for (int r = 0; r < (1 << IDX_W); r++) begin
            rd_idx = IDX_W'(r);
            #1;
            check(tag, 32'(rd_count), (r < NUM_OUT) ? 32'(model_cnt[r]) : 32'd0);
        end
        rd_idx = '0;
    endtask

    // Winner is the first index holding the maximum; tie if more than one holds it.
    task automatic check_result();
        int mx = -1;
        int win = 0;
        int nmx = 0;
        for (int i = 0; i < NUM_OUT; i++) if (model_cnt[i] > mx) begin mx = model_cnt[i]; win = i; end
        for (int i = 0; i < NUM_OUT; i++) if (model_cnt[i] == mx) nmx++;
        check("done", 32'(done), 32'd1);
        check("class", 32'(class_idx), 32'(win));
        check("class_count", 32'(class_count), 32'(mx));
        check("tie", 32'(tie), (nmx > 1) ? 32'd1 : 32'd0);
        check_counts("rd_count");
    endtask

    function automatic int rand_id();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, (1 << ID_W) - 1));
        return int'($urandom_range(0, NUM_OUT - 1));
    endfunction

    task automatic run_random(input int n);
        do_start(n);
        for (int s = 0; s < n; s++) begin
            int nc = int'($urandom_range(0, 6));
            for (int c = 0; c < nc; c++)
                cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), rand_id(), 1'b0,
                    bit'($urandom_range(0, 9) == 0));
            cyc(bit'($urandom_range(0, 1)), 1'b1, rand_id(), 1'b1, 1'b0);
        end
        wait_done(NUM_OUT + 1);
        check_result();
        // Traffic in DONE must not disturb the held result.
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, rand_id(), bit'($urandom_range(0, 1)), 1'b0);
        check_result();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_steps = '0;
        rd_idx = '0;
        spk_if.spike_valid_i = 1'b0;
        spk_if.spike_i       = 1'b0;
        spk_if.neuron_id_i   = '0;
        spk_if.step_done_i   = 1'b0;
        model_clear();
        model_accum = 0;
        model_n = 0;
        model_steps = 0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_class", 32'(class_idx), 32'd0);
        check("rst_ccount", 32'(class_count), 32'd0);
        check("rst_tie", 32'(tie), 32'd0);
        check_counts("rst_rd");
        rst = 1'b0;
        tick();

        // id 3 every step, id 7 in steps 0 and 1
        do_start(4);
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, 1'b1, 3, 1'b0, 1'b0);
            if (s < 2) cyc(1'b1, 1'b1, 7, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        wait_done(NUM_OUT + 1);
        check_result();
        check("t1_class", 32'(class_idx), 32'd3);
        check("t1_count", 32'(class_count), 32'd4);

        // tie between ids 2 and 5
        do_start(3);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 1'b1, 2, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 5, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        wait_done(NUM_OUT + 1);
        check_result();
        check("t2_tie", 32'(tie), 32'd1);

        // saturation
        do_start(1);
        for (int c = 0; c < 300; c++) cyc(1'b1, 1'b1, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        wait_done(NUM_OUT + 1);
        check_result();
        check("t3_sat", 32'(class_count), 32'd255);

        // out-of-range ids, ignored start, spike on final step
        do_start(2);
        cyc(1'b1, 1'b1, 10, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1023, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        num_steps = 8'd9;
        cyc(1'b1, 1'b1, 4, 1'b0, 1'b1);
        check("busy_start_ign", 32'(busy), 32'd1);
        cyc(1'b1, 1'b1, 4, 1'b1, 1'b0);
        wait_done(NUM_OUT + 1);
        check_result();
        check("t4_class", 32'(class_idx), 32'd4);

        // zero timesteps
        do_start(0);
        wait_done(NUM_OUT + 1);
        check_result();
        check("t5_tie", 32'(tie), 32'd1);

        // reset mid-accumulation
        do_start(4);
        for (int s = 0; s < 2; s++) begin
            cyc(1'b1, 1'b1, 6, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 8, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        model_accum = 0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_class", 32'(class_idx), 32'd0);
        check_counts("mid_rst_rd");
        do_start(4);
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, 1'b1, 9, 1'b0, 1'b0);
            if (s != 0) cyc(1'b1, 1'b1, 6, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        wait_done(NUM_OUT + 1);
        check_result();

        for (int t = 0; t < 8; t++) run_random(int'($urandom_range(1, 6)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
